// File: rtl/axi_addr_pkg.sv
// Shared encodings and the 4KB legality helper for the AXI address-channel responder.
package axi_addr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int unsigned BOUNDARY_4K = 4096;

  // Values double as the current_state_out encoding.
  typedef enum logic [2:0] {
    StReset = 3'b000,
    StIdle  = 3'b001,
    StBurst = 3'b010,
    StError = 3'b011
  } state_e;

  // True when an INCR burst from the size-aligned start would run past a 4KB page.
  function automatic logic crosses_4k(input logic [31:0] addr, input logic [7:0] len,
                                      input logic [2:0] size);
    logic [31:0] aligned;
    logic [31:0] span;
    aligned = addr & ~((32'd1 << size) - 32'd1);
    span    = ({24'd0, len} + 32'd1) << size;
    return ({20'd0, aligned[11:0]} + span) > BOUNDARY_4K;
  endfunction

endpackage

// File: rtl/axi_address_channel_responder_if.sv
// Address-channel inputs plus the beat-descriptor handshake toward the data engine.
interface axi_address_channel_responder_if #(
  parameter int unsigned ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] AxID;
  logic [31:0]         AxADDR;
  logic [7:0]          AxLEN;
  logic [2:0]          AxSIZE;
  logic [1:0]          AxBURST;
  logic                AxVALID;
  logic                AxREADY;
  logic                beat_valid;
  logic                beat_ready;
  logic [31:0]         beat_addr;
  logic [ID_WIDTH-1:0] beat_id;
  logic [7:0]          beat_index;
  logic                beat_last;
  logic                beat_err;

  modport master (
    output AxID, AxADDR, AxLEN, AxSIZE, AxBURST, AxVALID, beat_ready,
    input  AxREADY, beat_valid, beat_addr, beat_id, beat_index, beat_last, beat_err
  );

  modport slave (
    input  AxID, AxADDR, AxLEN, AxSIZE, AxBURST, AxVALID, beat_ready,
    output AxREADY, beat_valid, beat_addr, beat_id, beat_index, beat_last, beat_err
  );
endinterface

// File: rtl/axi_beat_addr_gen.sv
// Combinational next-beat address: FIXED holds, otherwise step from the size-aligned address.
module axi_beat_addr_gen
  import axi_addr_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);
  logic [31:0] bytes;

  always_comb begin
    bytes = 32'd1 << size;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else begin
      next_addr = (addr & ~(bytes - 32'd1)) + bytes;
    end
  end
endmodule

// File: rtl/axi_address_channel_responder.sv
// Accepts one AXI address transfer, checks legality, then emits one descriptor per data beat.
module axi_address_channel_responder
  import axi_addr_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned MAX_SIZE = 2
) (
  input  logic                             clk,
  input  logic                             resetn,
  axi_address_channel_responder_if.slave   bus,
  output logic                             busy,
  output logic [2:0]                       current_state_out
);
  state_e              state_q;
  logic                ax_ready_q;
  logic                beat_valid_q;
  logic [31:0]         addr_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [7:0]          index_q;
  logic                last_q;
  logic                err_q;
  logic                busy_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [31:0]         next_addr;
  logic                illegal;

  always_comb begin
    illegal = 1'b0;
    if (bus.AxBURST == BURST_WRAP || bus.AxBURST == 2'b11) illegal = 1'b1;
    if (32'(bus.AxSIZE) > MAX_SIZE) illegal = 1'b1;
    if (bus.AxBURST == BURST_INCR && crosses_4k(bus.AxADDR, bus.AxLEN, bus.AxSIZE)) begin
      illegal = 1'b1;
    end
  end

  axi_beat_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StReset;
      ax_ready_q   <= 1'b0;
      beat_valid_q <= 1'b0;
      addr_q       <= '0;
      id_q         <= '0;
      index_q      <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
    end else begin
      case (state_q)
        StReset: begin
          state_q    <= StIdle;
          ax_ready_q <= 1'b1;
        end
        StIdle: begin
          if (bus.AxVALID) begin
            id_q         <= bus.AxID;
            addr_q       <= bus.AxADDR;
            len_q        <= bus.AxLEN;
            size_q       <= bus.AxSIZE;
            burst_q      <= bus.AxBURST;
            index_q      <= '0;
            last_q       <= (bus.AxLEN == 8'd0);
            err_q        <= illegal;
            ax_ready_q   <= 1'b0;
            beat_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= illegal ? StError : StBurst;
          end
        end
        StBurst, StError: begin
          if (beat_valid_q && bus.beat_ready) begin
            if (last_q) begin
              state_q      <= StIdle;
              ax_ready_q   <= 1'b1;
              beat_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              last_q       <= 1'b0;
              err_q        <= 1'b0;
            end else begin
              index_q <= index_q + 8'd1;
              last_q  <= ((index_q + 8'd1) == len_q);
              // Rejected bursts keep reporting the captured address on every beat.
              if (state_q == StBurst) addr_q <= next_addr;
            end
          end
        end
        default: state_q <= StReset;
      endcase
    end
  end

  assign bus.AxREADY        = ax_ready_q;
  assign bus.beat_valid     = beat_valid_q;
  assign bus.beat_addr      = addr_q;
  assign bus.beat_id        = id_q;
  assign bus.beat_index     = index_q;
  assign bus.beat_last      = last_q;
  assign bus.beat_err       = err_q;
  assign busy               = busy_q;
  assign current_state_out  = state_q;
endmodule
